// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD text scheduler.
//   NREQ        : number of requesters
//   LCD_TEXT_W  : default width of one text buffer (34 characters x 8 bits)
//   state_e     : scheduler FSM encoding
//   onehot4     : index -> one-hot requester mask
package lcd_pkg;

    localparam int NREQ       = 4;
    localparam int LCD_TEXT_W = 272;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARB,
        ST_LOAD,
        ST_SEND,
        ST_WAIT,
        ST_DONE
    } state_e;

    function automatic logic [NREQ-1:0] onehot4(input logic [1:0] idx);
        return NREQ'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Four-way round-robin selector (purely combinational).
//   pending    in  4 : outstanding requests
//   last_grant in  2 : most recently served index
//   grant      out 2 : first pending index after last_grant, wrapping 3 -> 0
//   valid      out 1 : at least one request pending
module rr_arbiter4
    import lcd_pkg::*;
(
    input  logic [NREQ-1:0] pending,
    input  logic [1:0]      last_grant,
    output logic [1:0]      grant,
    output logic            valid
);

    logic [1:0] idx;

    // k runs 1..4 so last_grant itself is considered last.
    always_comb begin
        grant = last_grant;
        valid = 1'b0;
        idx   = last_grant;
        for (int k = 1; k <= NREQ; k++) begin
            idx = last_grant + 2'(k);
            if (!valid && pending[idx]) begin
                grant = idx;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lcd_text_scheduler.sv
// Arbitrates four text sources onto one LCD sender.
//   CLK, RST           : clock, async active-high reset
//   req[3:0]           : one-cycle request pulses
//   txt0..txt3         : per-requester text, held stable until ack/timeout
//   sending_done       : sender completion pulse (honoured only in WAIT)
//   send_text          : one-cycle start pulse to the sender
//   text               : latched text of the granted requester
//   ack[3:0]           : one-hot completion pulse
//   busy               : transfer in progress
//   timeout            : one-cycle abort pulse
module lcd_text_scheduler
    import lcd_pkg::*;
#(
    parameter int TEXT_W  = LCD_TEXT_W,
    parameter int TIMEOUT = 50000000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [NREQ-1:0]   req,
    input  logic [TEXT_W-1:0] txt0,
    input  logic [TEXT_W-1:0] txt1,
    input  logic [TEXT_W-1:0] txt2,
    input  logic [TEXT_W-1:0] txt3,
    input  logic              sending_done,
    output logic              send_text,
    output logic [TEXT_W-1:0] text,
    output logic [NREQ-1:0]   ack,
    output logic              busy,
    output logic              timeout
);

    localparam int            CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_e            state_q;
    logic [NREQ-1:0]   pending_q, pending_d;
    logic [1:0]        last_grant_q, grant_q;
    logic              requeue_q;
    logic [CW-1:0]     cnt_q;
    logic [TEXT_W-1:0] text_q, txt_sel;
    logic              send_text_q, busy_q, timeout_q;
    logic [NREQ-1:0]   ack_q;

    logic [1:0] arb_grant;
    logic       arb_valid;
    logic       done_hit, tmo_hit, xfer_end;

    rr_arbiter4 u_arb (
        .pending    (pending_q),
        .last_grant (last_grant_q),
        .grant      (arb_grant),
        .valid      (arb_valid)
    );

    assign done_hit = (state_q == ST_WAIT) && sending_done;
    assign tmo_hit  = (state_q == ST_WAIT) && !sending_done && (cnt_q == CNT_LAST);
    assign xfer_end = (state_q == ST_DONE) || tmo_hit;

    // The granted bit is released as the ack/timeout becomes visible, so the
    // following IDLE cycle never re-grants it. A repeat request seen since
    // LOAD (requeue_q) or in this very cycle keeps it pending.
    always_comb begin
        pending_d = pending_q | req;
        if (xfer_end && !requeue_q) begin
            pending_d[grant_q] = req[grant_q];
        end
    end

    always_comb begin
        case (grant_q)
            2'd0:    txt_sel = txt0;
            2'd1:    txt_sel = txt1;
            2'd2:    txt_sel = txt2;
            default: txt_sel = txt3;
        endcase
    end

    // busy is registered from the state being entered, and also held for the
    // cycle that carries ack/timeout, so it drops one cycle after completion.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            pending_q    <= '0;
            last_grant_q <= 2'd3;
            grant_q      <= 2'd0;
            requeue_q    <= 1'b0;
            cnt_q        <= '0;
            text_q       <= '0;
            send_text_q  <= 1'b0;
            ack_q        <= '0;
            busy_q       <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            pending_q   <= pending_d;
            send_text_q <= 1'b0;
            ack_q       <= '0;
            timeout_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    requeue_q <= 1'b0;
                    busy_q    <= |pending_d;
                    if (|pending_d) begin
                        state_q <= ST_ARB;
                    end
                end
                ST_ARB: begin
                    busy_q    <= 1'b1;
                    requeue_q <= 1'b0;
                    if (arb_valid) begin
                        grant_q <= arb_grant;
                        state_q <= ST_LOAD;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    busy_q       <= 1'b1;
                    text_q       <= txt_sel;
                    last_grant_q <= grant_q;
                    send_text_q  <= 1'b1;
                    requeue_q    <= requeue_q | req[grant_q];
                    state_q      <= ST_SEND;
                end
                ST_SEND: begin
                    busy_q    <= 1'b1;
                    cnt_q     <= '0;
                    requeue_q <= requeue_q | req[grant_q];
                    state_q   <= ST_WAIT;
                end
                ST_WAIT: begin
                    busy_q <= 1'b1;
                    if (done_hit) begin
                        requeue_q <= requeue_q | req[grant_q];
                        state_q   <= ST_DONE;
                    end else if (tmo_hit) begin
                        requeue_q <= 1'b0;
                        timeout_q <= 1'b1;
                        state_q   <= ST_IDLE;
                    end else begin
                        requeue_q <= requeue_q | req[grant_q];
                        cnt_q     <= cnt_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    busy_q    <= 1'b1;
                    requeue_q <= 1'b0;
                    ack_q     <= onehot4(grant_q);
                    state_q   <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign send_text = send_text_q;
    assign text      = text_q;
    assign ack       = ack_q;
    assign busy      = busy_q;
    assign timeout   = timeout_q;

endmodule
